// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART transmitter between
// NREQ byte sources. Captures the winner's byte, strobes the transmitter,
// follows its busy indication through the frame and returns ack/err pulses.
module uart_tx_sched #(
  parameter int NREQ      = 4,
  parameter int WR_HOLD   = 2,
  parameter int START_TMO = 8,
  parameter int GAP       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              sched_busy
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] STROBE     = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] WAIT_END   = 3'd3;
  localparam logic [2:0] GAP_ST     = 3'd4;

  // Leaving a frame goes straight to IDLE when no gap is configured.
  localparam logic [2:0] AFTER_FRAME = (GAP == 0) ? IDLE : GAP_ST;

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(WR_HOLD + 1);
  localparam int TW = $clog2(START_TMO + 1);
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  logic [2:0]      state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic [NREQ-1:0] err_reg, err_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic            tx_wr_reg, tx_wr_next;
  logic [PW-1:0]   rr_reg, rr_next;
  logic [HW-1:0]   hold_reg, hold_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [GW-1:0]   gap_reg, gap_next;

  logic [7:0]      src_byte [NREQ];
  logic [PW-1:0]   rot_idx [NREQ];
  logic [NREQ-1:0] rot_req;
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;

  // Per-source byte lanes and request vector rotated so that position 0 is
  // the source the round-robin pointer currently favours.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [PW:0] sum;
      assign src_byte[gi] = req_data[8*gi +: 8];
      assign sum          = {1'b0, rr_reg} + (PW+1)'(gi);
      assign rot_idx[gi]  = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                   : sum[PW-1:0];
      assign rot_req[gi]  = req[rot_idx[gi]];
    end
  endgenerate

  // First requesting source at or after the pointer wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_valid = 1'b1;
        win_idx   = rot_idx[k];
      end
    end
    win_onehot = NREQ'(1) << win_idx;
  end

  // Scheduler FSM: next-state and next-output computation.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ack_next     = '0;
    err_next     = '0;
    tx_data_next = tx_data_reg;
    tx_wr_next   = tx_wr_reg;
    rr_next      = rr_reg;
    hold_next    = hold_reg;
    tmo_next     = tmo_reg;
    gap_next     = gap_reg;
    case (state_reg)
      IDLE: begin
        // A busy line here means someone else's frame; wait it out.
        if (win_valid && !tx_busy) begin
          grant_next   = win_onehot;
          tx_data_next = src_byte[win_idx];
          rr_next      = (win_idx == PW'(NREQ - 1)) ? '0 : PW'(win_idx + 1'b1);
          hold_next    = '0;
          tmo_next     = '0;
          state_next   = STROBE;
        end
      end
      STROBE: begin
        // Start timer runs from the first strobe cycle; saturate so a long
        // strobe cannot wrap it.
        if (tmo_reg != TW'(START_TMO)) begin
          tmo_next = tmo_reg + TW'(1);
        end
        if (hold_reg < HW'(WR_HOLD)) begin
          tx_wr_next = 1'b1;
          hold_next  = hold_reg + HW'(1);
        end else begin
          tx_wr_next = 1'b0;
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_next = WAIT_END;
        end else if (tmo_reg == TW'(START_TMO)) begin
          err_next   = grant_reg;
          grant_next = '0;
          gap_next   = '0;
          state_next = AFTER_FRAME;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      WAIT_END: begin
        // Frame length belongs to the transmitter, so no timeout here.
        if (!tx_busy) begin
          ack_next   = grant_reg;
          grant_next = '0;
          gap_next   = '0;
          state_next = AFTER_FRAME;
        end
      end
      GAP_ST: begin
        if (gap_reg == GW'(GAP - 1)) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + GW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        tx_wr_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame without ack/err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      ack_reg     <= '0;
      err_reg     <= '0;
      tx_data_reg <= 8'h00;
      tx_wr_reg   <= 1'b0;
      rr_reg      <= '0;
      hold_reg    <= '0;
      tmo_reg     <= '0;
      gap_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      tx_data_reg <= tx_data_next;
      tx_wr_reg   <= tx_wr_next;
      rr_reg      <= rr_next;
      hold_reg    <= hold_next;
      tmo_reg     <= tmo_next;
      gap_reg     <= gap_next;
    end
  end

  assign grant      = grant_reg;
  assign ack        = ack_reg;
  assign err        = err_reg;
  assign tx_data    = tx_data_reg;
  assign tx_wr      = tx_wr_reg;
  assign sched_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: drives requests and a hand-scripted
// transmitter busy line, checks every observation at the falling edge.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        sched_busy;

  int errors = 0;
  int checks = 0;

  uart_tx_sched #(
    .NREQ(4), .WR_HOLD(2), .START_TMO(8), .GAP(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .grant(grant), .tx_data(tx_data),
    .tx_wr(tx_wr), .tx_busy(tx_busy), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until the scheduler is back in IDLE.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (sched_busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, sched_busy}, 32'd0);
  endtask

  // One complete frame: wait for the grant, check it, script the busy line
  // dly cycles after tx_wr rises for len cycles, then check the ack pulse.
  // With mangle set, the source's byte and request are disturbed mid-frame.
  task automatic do_frame(input int idx, input logic [7:0] exp_d,
                          input int dly, input int len, input bit mangle);
    int n = 0;
    int wr_hi = 0;
    int data_bad = 0;
    int early = 0;
    logic [3:0] exp_g;
    exp_g = 4'b0001 << idx;
    while (grant === 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("grant", {28'd0, grant}, {28'd0, exp_g});
    chk("tx_data_at_grant", {24'd0, tx_data}, {24'd0, exp_d});
    chk("tx_wr_at_grant", {31'd0, tx_wr}, 32'd0);
    for (int c = 1; c <= 3 + dly + len; c++) begin
      @(negedge clk);
      if (c == 1) chk("tx_wr_rise", {31'd0, tx_wr}, 32'd1);
      if (tx_wr === 1'b1) wr_hi++;
      if (c < 2 + dly + len) begin
        if (tx_data !== exp_d) data_bad++;
        if (ack !== 4'b0 || err !== 4'b0) early++;
      end
      if (c == 2 + dly + len) begin
        chk("ack_pulse", {28'd0, ack}, {28'd0, exp_g});
        chk("err_none", {28'd0, err}, 32'd0);
        chk("grant_clear", {28'd0, grant}, 32'd0);
      end
      if (c == 3 + dly + len) chk("ack_single", {28'd0, ack}, 32'd0);
      if (c == 1 && mangle) begin
        req_data[8*idx +: 8] = 8'hFF;
        req = 4'b0000;
      end
      if (c == 1 + dly) tx_busy = 1'b1;
      if (c == 1 + dly + len) tx_busy = 1'b0;
    end
    chk("tx_wr_hold_cycles", wr_hi, 2);
    chk("tx_data_stable", data_bad, 0);
    chk("no_early_pulse", early, 0);
    $display("frame src=%0d data=%02h busy_dly=%0d busy_len=%0d mangle=%0d", idx, exp_d, dly, len, mangle);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    req = 4'b0;
    req_data = 32'h0;
    tx_busy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_err", {28'd0, err}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("rst_sched_busy", {31'd0, sched_busy}, 32'd0);
    $display("reset checked");
    rst = 1'b0;
    @(negedge clk);

    // All four requesting: served 0,1,2,3,0
    req_data = 32'h43322110;
    req = 4'b1111;
    do_frame(0, 8'h10, 2, 6, 1'b0);
    do_frame(1, 8'h21, 2, 6, 1'b0);
    do_frame(2, 8'h32, 2, 6, 1'b0);
    do_frame(3, 8'h43, 2, 6, 1'b0);
    do_frame(0, 8'h10, 2, 6, 1'b0);
    req = 4'b0000;
    wait_idle("rr");

    // Single request, long frame, then 16 gap cycles
    req_data = 32'h00A50000;
    req = 4'b0100;
    do_frame(2, 8'hA5, 3, 169, 1'b0);
    req = 4'b0000;
    n = 1;
    while (sched_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("gap_cycles_after_ack", n, 16);
    $display("single request gap=%0d", n);

    // Start timeout: busy never rises
    req_data = 32'h0000005A;
    req = 4'b0001;
    n = 0;
    while (grant === 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_grant", {28'd0, grant}, 32'd1);
    @(negedge clk);
    chk("tmo_tx_wr_rise", {31'd0, tx_wr}, 32'd1);
    n = 0;
    bad = 0;
    while (err === 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
      if (ack !== 4'b0) bad++;
    end
    chk("tmo_err_delay", n, 8);
    chk("tmo_err", {28'd0, err}, 32'd1);
    chk("tmo_no_ack", bad, 0);
    n = 0;
    while (grant === 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("tmo_err_single", {28'd0, err}, 32'd0);
    end
    chk("tmo_regrant_delay", n, 17);
    $display("timeout err_delay=8 regrant_delay=%0d", n);
    do_frame(0, 8'h5A, 2, 6, 1'b0);
    req = 4'b0000;
    wait_idle("tmo");

    // Busy line held in IDLE blocks the grant
    req_data = 32'h00007700;
    tx_busy = 1'b1;
    req = 4'b0010;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (grant !== 4'b0 || tx_wr !== 1'b0 || sched_busy !== 1'b0) bad++;
    end
    chk("busy_idle_no_grant", bad, 0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_grant", {28'd0, grant}, 32'd2);
    $display("busy in idle blocked=%0d", bad);
    do_frame(1, 8'h77, 2, 6, 1'b0);
    wait_idle("busy");

    // Data and request change mid-frame
    req_data = 32'h3C000000;
    req = 4'b1000;
    do_frame(3, 8'h3C, 2, 6, 1'b1);
    wait_idle("mangle");

    // Reset during WAIT_END, then pointer must be back at 0
    req_data = 32'h00009900;
    req = 4'b0010;
    n = 0;
    while (grant === 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_grant", {28'd0, grant}, 32'd2);
    repeat (3) @(negedge clk);
    tx_busy = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid_busy_before", {31'd0, sched_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_grant0", {28'd0, grant}, 32'd0);
    chk("rstmid_tx_wr0", {31'd0, tx_wr}, 32'd0);
    chk("rstmid_ack0", {28'd0, ack}, 32'd0);
    chk("rstmid_err0", {28'd0, err}, 32'd0);
    chk("rstmid_tx_data0", {24'd0, tx_data}, 32'd0);
    chk("rstmid_idle", {31'd0, sched_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tx_busy = 1'b0;
    req_data = 32'h44332211;
    req = 4'b1111;
    @(negedge clk);
    chk("rstmid_rr0_grant", {28'd0, grant}, 32'd1);
    $display("reset mid-frame checked");
    do_frame(0, 8'h11, 2, 6, 1'b0);
    req = 4'b0000;
    wait_idle("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter between NREQ byte sources. It captures a winning requester's byte and drives the transmitter's data and write-strobe inputs. It then tracks the transmitter's busy/idle indication through the whole frame and returns a per-requester completion or error pulse. It sits between the protocol/test-pattern sources and the 16-clock-per-bit UART transmitter, on the same UART clock.

Parameters:
NREQ, 4, number of requesters (2..8)
WR_HOLD, 2, cycles tx_wr is held high per frame (transmitter edge-detects wr, so it must be at least 1)
START_TMO, 8, max cycles from tx_wr rise to tx_busy high before abort
GAP, 16, idle cycles inserted after tx_busy falls before next grant

Ports:
clk  in  1  UART clock, same as transmitter
rst  in  1  asynchronous reset, active-high
req  in  NREQ  level request per source; held until ack/err
req_data  in  8*NREQ  byte per source; source i occupies bits [8i+7:8i]
ack  out  NREQ  one-cycle pulse: frame for source i completed
err  out  NREQ  one-cycle pulse: transmitter never went busy for source i
grant  out  NREQ  one-hot, source currently owning transmitter
tx_data  out  8  byte to transmitter; stable for entire frame
tx_wr  out  1  write strobe to transmitter (rising edge starts frame)
tx_busy  in  1  transmitter line status, 1 = busy, 0 = idle
sched_busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, grant=0, ack=0, err=0, tx_data=8'h00, tx_wr=0, rr pointer=0, all counters 0. Reset mid-frame abandons the frame with no ack/err. The transmitter is reset separately.
- States: IDLE -> STROBE -> WAIT_START -> WAIT_END -> GAP -> IDLE.
- IDLE: if any req bit is set and tx_busy=0, pick the first set bit searching from the rr pointer upward, modulo NREQ. Register grant (one-hot) and tx_data <= that source's byte, then go to STROBE. If tx_busy=1 in IDLE, do not grant; a foreign or left-over frame is in progress.
- STROBE: tx_wr=1 for exactly WR_HOLD cycles, then tx_wr=0 and go to WAIT_START. The start timer begins on the first STROBE cycle.
- WAIT_START: on tx_busy=1, go to WAIT_END. If the timer reaches START_TMO with tx_busy still 0, pulse err[grant] one cycle, clear grant, and go to GAP.
- WAIT_END: on tx_busy=0, pulse ack[grant] one cycle, clear grant, and go to GAP. There is no timeout here; the frame length is owned by the transmitter.
- GAP: count GAP cycles, then go to IDLE. GAP=0 means go straight to IDLE next cycle.
- rr pointer: on leaving IDLE with winner w, pointer <= (w+1) mod NREQ. Fairness: with all requests constantly asserted, sources are served 0,1,2,...,NREQ-1,0,...
- tx_data is loaded only in IDLE on grant and is held unchanged through STROBE/WAIT_START/WAIT_END. The transmitter samples data throughout the frame.
- req_data of the granted source is captured once; later changes are ignored until the next grant.
- A req deasserted after grant does not abort the frame; ack/err is still pulsed.
- A source whose req stays high after ack is re-eligible only after GAP, and only in round-robin turn.
- ack and err are mutually exclusive, at most one bit set, and only for the source that was granted.
- Grant decision latency: 1 cycle from req seen in IDLE to grant/tx_data valid. tx_wr rises the following cycle.
- Counters are sized for their parameters; no wrap-around occurs within legal parameter ranges.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5, transmitter model goes busy 3 cycles after tx_wr rise and stays busy 169 cycles -> grant=4'b0100, tx_data=8'hA5 stable throughout, tx_wr high 2 cycles, ack=4'b0100 single pulse after busy falls, then IDLE after 16 gap cycles.
- All four requesting continuously with bytes 8'h10,8'h21,8'h32,8'h43 -> tx_data sequence 10,21,32,43,10; exactly one ack per frame, in order 0,1,2,3,0.
- Start timeout: tie tx_busy=0, req=4'b0001 -> err=4'b0001 one pulse 8 cycles after tx_wr rise, no ack, then source 0 re-granted after gap.
- Busy in IDLE: hold tx_busy=1 with req=4'b0010 -> no grant and tx_wr stays 0; release tx_busy -> grant=4'b0010 next cycle.
- Data/req change mid-frame: after grant, change req_data to 8'hFF and drop req -> tx_data keeps original 8'h3C, ack still pulsed.
- Reset mid-frame: assert rst during WAIT_END -> grant, tx_wr, ack, err and tx_data go to 0 immediately, state IDLE, rr pointer 0.
